uart_rx_fifo: RTL

Receive buffer directly downstream of the UART receiver. Captures each byte the receiver delivers on its `rx_done` pulse, together with that frame's stop-bit (framing) error flag. Holds the bytes in a first-word-fall-through FIFO for the APB register block to drain. Also tracks fill level, generates a threshold interrupt and flags overrun when a byte arrives while the FIFO is full.

---
 rtl/uart_rx_fifo.sv | 63 ++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer for UART bytes with framing flags, level, threshold irq and overrun.
// Inputs:  clk, rx_rst_n (async low), rx_done/rx_error/din from the receiver,
//          rd_en pop, fifo_clr flush, ovr_clr overrun clear, thr irq threshold (0 = off).
// Outputs: rd_data/rd_ferr head entry (0 when empty), count, empty, full, overrun, rx_irq.
module uart_rx_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rx_rst_n,
  input  logic                 rx_done,
  input  logic                 rx_error,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 rd_en,
  input  logic                 fifo_clr,
  input  logic                 ovr_clr,
  input  logic [AW:0]          thr,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_ferr,
  output logic [AW:0]          count,
  output logic                 empty,
  output logic                 full,
  output logic                 overrun,
  output logic                 rx_irq
);
  logic [DATAWIDTH:0] mem_q [DEPTH];
  logic [DATAWIDTH:0] head;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] count_q, count_d;
  logic overrun_q, overrun_d;
  logic wr, rd;
  always_comb begin
    empty = count_q == '0;
    full = count_q == (AW+1)'(DEPTH);
    // a full FIFO still accepts a byte when the head is popped in the same cycle
    wr = rx_done && (!full || rd_en) && !fifo_clr;
    rd = rd_en && !empty && !fifo_clr;
    wp_d = fifo_clr ? '0 : wp_q + AW'(wr);
    rp_d = fifo_clr ? '0 : rp_q + AW'(rd);
    count_d = fifo_clr ? '0 : count_q + (AW+1)'(wr) - (AW+1)'(rd);
    overrun_d = fifo_clr ? 1'b0 : (rx_done && full && !rd_en) ? 1'b1 : ovr_clr ? 1'b0 : overrun_q;
    head = mem_q[rp_q];
    rd_data = empty ? '0 : head[DATAWIDTH-1:0];
    rd_ferr = empty ? 1'b0 : head[DATAWIDTH];
    count = count_q;
    overrun = overrun_q;
    rx_irq = thr != '0 && count_q >= thr;
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= {rx_error, din};
  always_ff @(posedge clk or negedge rx_rst_n)
    if (!rx_rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      overrun_q <= overrun_d;
    end
endmodule
